// File: rtl/rtc_param_editor.sv
// Date/time/timer field editor for the RTC front end: BCD fields with wrap-around,
// auto-repeating value buttons and a listo/ack handoff to the RTC write sequencer.
module rtc_param_editor #(
    parameter int unsigned N_FIELDS     = 9,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_num,
    input  logic                    down_num,
    input  logic                    up_par,
    input  logic                    down_par,
    input  logic                    clr,
    input  logic                    forma,
    input  logic                    ld,
    input  logic                    ack,
    output logic [8*N_FIELDS-1:0]   fields,
    output logic [N_FIELDS-1:0]     habilita,
    output logic                    listo,
    output logic                    busy
);

    localparam int unsigned CNT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned HOUR_IDX = 2;
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

    typedef enum logic {EDIT, WAIT_ACK} state_e;

    // Legal BCD range of each field; only hours depends on the 12 h flag.
    function automatic logic [7:0] fmin(input int unsigned idx, input logic f12);
        case (idx)
            2:       fmin = f12 ? 8'h01 : 8'h00;
            3, 4:    fmin = 8'h01;
            default: fmin = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] fmax(input int unsigned idx, input logic f12);
        case (idx)
            2:       fmax = f12 ? 8'h12 : 8'h23;
            3:       fmax = 8'h31;
            4:       fmax = 8'h12;
            5:       fmax = 8'h99;
            8:       fmax = 8'h23;
            default: fmax = 8'h59;
        endcase
    endfunction

    // Comparisons with >= / <= keep a transiently out-of-range hour well behaved.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (v >= mx)
            bcd_inc = mn;
        else if (v[3:0] >= 4'd9)
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else
            bcd_inc = v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (v <= mn)
            bcd_dec = mx;
        else if (v[3:0] == 4'd0)
            bcd_dec = {v[7:4] - 4'd1, 4'd9};
        else
            bcd_dec = v - 8'd1;
    endfunction

    // 24 h -> 12 h display fold: 00 -> 12, 13..23 -> 01..11, others unchanged.
    function automatic logic [7:0] hr12(input logic [7:0] v);
        if (v == 8'h00)
            hr12 = 8'h12;
        else if (v < 8'h13)
            hr12 = v;
        else if (v[7:4] == 4'd1)
            hr12 = {4'd0, v[3:0] - 4'd2};
        else if (v[3:0] <= 4'd1)
            hr12 = {4'd0, v[3:0] + 4'd8};
        else
            hr12 = {4'd1, v[3:0] - 4'd2};
    endfunction

    state_e             state_q, state_d;
    logic [7:0]         fld_q [N_FIELDS];
    logic [7:0]         fld_d [N_FIELDS];
    logic [N_FIELDS-1:0] hab_q, hab_d;
    logic               up_num_q, down_num_q, up_par_q, down_par_q, ld_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               rep_q, rep_d;
    logic               act_q, act_d;
    logic               do_step;
    logic               up_num_e, down_num_e, sel_up, sel_dn, ld_e;

    assign up_num_e   = up_num & ~up_num_q;
    assign down_num_e = down_num & ~down_num_q;
    assign sel_up     = up_par & ~up_par_q & ~(down_par & ~down_par_q);
    assign sel_dn     = down_par & ~down_par_q & ~(up_par & ~up_par_q);
    assign ld_e       = ld & ~ld_q;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EDIT;
            for (int unsigned i = 0; i < N_FIELDS; i++)
                fld_q[i] <= fmin(i, 1'b0);
            hab_q      <= N_FIELDS'(1);
            up_num_q   <= 1'b0;
            down_num_q <= 1'b0;
            up_par_q   <= 1'b0;
            down_par_q <= 1'b0;
            ld_q       <= 1'b0;
            cnt_q      <= '0;
            rep_q      <= 1'b0;
            act_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            for (int unsigned i = 0; i < N_FIELDS; i++)
                fld_q[i] <= fld_d[i];
            hab_q      <= hab_d;
            up_num_q   <= up_num;
            down_num_q <= down_num;
            up_par_q   <= up_par;
            down_par_q <= down_par;
            ld_q       <= ld;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            act_q      <= act_d;
        end
    end

    // Next state: clr > ld > field select > value step; repeat state clears unless held.
    always_comb begin
        state_d = state_q;
        for (int unsigned i = 0; i < N_FIELDS; i++)
            fld_d[i] = fld_q[i];
        hab_d   = hab_q;
        cnt_d   = '0;
        rep_d   = 1'b0;
        act_d   = 1'b0;
        do_step = 1'b0;

        if (clr) begin
            state_d = EDIT;
            for (int unsigned i = 0; i < N_FIELDS; i++)
                fld_d[i] = fmin(i, 1'b0);
            hab_d = N_FIELDS'(1);
        end else if (state_q == WAIT_ACK) begin
            if (ack)
                state_d = EDIT;
        end else begin
            if (en && ld_e) begin
                state_d = WAIT_ACK;
            end else if (en && (sel_up || sel_dn)) begin
                for (int unsigned i = 0; i < N_FIELDS; i++)
                    hab_d[i] = sel_up ? hab_q[(i + N_FIELDS - 1) % N_FIELDS]
                                      : hab_q[(i + 1) % N_FIELDS];
            end else if (en && (up_num ^ down_num)) begin
                if ((up_num && up_num_e) || (down_num && down_num_e)) begin
                    do_step = 1'b1;
                    act_d   = 1'b1;
                end else if (act_q) begin
                    act_d = 1'b1;
                    if (cnt_inc == (rep_q ? RATE_C : DELAY_C)) begin
                        do_step = 1'b1;
                        rep_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        rep_d = rep_q;
                    end
                end
            end

            for (int unsigned i = 0; i < N_FIELDS; i++) begin
                if (do_step && hab_q[i]) begin
                    if (up_num)
                        fld_d[i] = bcd_inc(fld_q[i], fmin(i, forma), fmax(i, forma));
                    else
                        fld_d[i] = bcd_dec(fld_q[i], fmin(i, forma), fmax(i, forma));
                end
                if (i == HOUR_IDX && forma && state_d == EDIT)
                    fld_d[i] = hr12(fld_d[i]);
            end
        end
    end

    always_comb begin
        fields = '0;
        for (int unsigned i = 0; i < N_FIELDS; i++)
            fields[8*i +: 8] = fld_q[i];
    end

    assign habilita = hab_q;
    assign listo    = (state_q == WAIT_ACK);
    assign busy     = (state_q == WAIT_ACK);

endmodule

// File: tb/tb_rtc_param_editor.sv
// Directed bench for rtc_param_editor with short repeat timing (delay 4, rate 2).
module tb_rtc_param_editor;

    localparam int unsigned NF = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en, up_num, down_num, up_par, down_par, clr, forma, ld, ack;
    logic [8*NF-1:0] fields;
    logic [NF-1:0]   habilita;
    logic            listo, busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [71:0] RST_FIELDS = 72'h00_00_00_00_01_01_00_00_00;

    rtc_param_editor #(.N_FIELDS(NF), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_num(up_num), .down_num(down_num),
        .up_par(up_par), .down_par(down_par), .clr(clr), .forma(forma), .ld(ld),
        .ack(ack), .fields(fields), .habilita(habilita), .listo(listo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle press followed by one idle cycle.
    task automatic press(input int b);
        case (b)
            0: up_num   = 1'b1;
            1: down_num = 1'b1;
            2: up_par   = 1'b1;
            3: down_par = 1'b1;
            default: ld = 1'b1;
        endcase
        tick();
        up_num = 1'b0; down_num = 1'b0; up_par = 1'b0; down_par = 1'b0; ld = 1'b0;
        tick();
    endtask

    localparam int UPN = 0, DNN = 1, UPP = 2, DNP = 3, LD = 4;

    logic [7:0] rep_exp [9];
    logic [71:0] snap;

    initial begin
        rep_exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04};
        rst_n = 1'b0; en = 1'b1; up_num = 0; down_num = 0; up_par = 0; down_par = 0;
        clr = 0; forma = 0; ld = 0; ack = 0;
        repeat (3) tick();
        check("rst_fields", 72'(fields), RST_FIELDS);
        check("rst_hab", 72'(habilita), 72'h001);
        check("rst_listo", 72'(listo), 72'h0);
        check("rst_busy", 72'(busy), 72'h0);
        rst_n = 1'b1;
        tick();

        // Seconds: up from 00, down twice wraps to 59.
        press(UPN);
        check("sec_inc", 72'(fields[7:0]), 72'h01);
        press(DNN);
        check("sec_dec", 72'(fields[7:0]), 72'h00);
        press(DNN);
        check("sec_wrap", 72'(fields[7:0]), 72'h59);

        // en low blocks buttons.
        en = 1'b0;
        press(UPN);
        press(UPP);
        en = 1'b1;
        check("en_off_val", 72'(fields[7:0]), 72'h59);
        check("en_off_sel", 72'(habilita), 72'h001);

        // Month.
        repeat (4) press(UPP);
        check("sel_month", 72'(habilita), 72'h010);
        press(DNN);
        check("month_dec", 72'(fields[39:32]), 72'h12);
        press(UPN);
        check("month_inc", 72'(fields[39:32]), 72'h01);

        // Hours and 12 h folding.
        repeat (2) press(DNP);
        check("sel_hours", 72'(habilita), 72'h004);
        press(DNN);
        check("hr_wrap24", 72'(fields[23:16]), 72'h23);
        forma = 1'b1;
        tick();
        check("hr_fold23", 72'(fields[23:16]), 72'h11);
        press(UPN);
        check("hr12_inc", 72'(fields[23:16]), 72'h12);
        press(UPN);
        check("hr12_wrap", 72'(fields[23:16]), 72'h01);
        forma = 1'b0;
        press(DNN);
        check("hr24_dec", 72'(fields[23:16]), 72'h00);
        forma = 1'b1;
        tick();
        check("hr_fold00", 72'(fields[23:16]), 72'h12);
        forma = 1'b0;
        tick();
        check("hr_keep24", 72'(fields[23:16]), 72'h12);

        // Auto-repeat on minutes: steps at held edges 0, 4, 6, 8.
        press(DNP);
        check("sel_min", 72'(habilita), 72'h002);
        up_num = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rep_%0d", i), 72'(fields[15:8]), 72'(rep_exp[i]));
        end
        up_num = 1'b0;
        tick();
        check("rep_release", 72'(fields[15:8]), 72'h04);

        // Load handshake.
        snap = 72'h00_00_00_00_01_01_12_04_59;
        check("pre_ld", 72'(fields), snap);
        ld = 1'b1;
        tick();
        ld = 1'b0;
        check("ld_listo", 72'(listo), 72'h1);
        check("ld_busy", 72'(busy), 72'h1);
        press(UPN);
        press(UPP);
        check("frozen_f", 72'(fields), snap);
        check("frozen_h", 72'(habilita), 72'h002);
        check("still_listo", 72'(listo), 72'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_listo", 72'(listo), 72'h0);
        check("ack_busy", 72'(busy), 72'h0);
        check("ack_fields", 72'(fields), snap);

        // clr inside WAIT_ACK.
        press(LD);
        check("ld2_listo", 72'(listo), 72'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_wait_listo", 72'(listo), 72'h0);
        check("clr_wait_f", 72'(fields), RST_FIELDS);

        // ld and clr together: clr wins.
        press(UPN);
        ld = 1'b1; clr = 1'b1;
        tick();
        ld = 1'b0; clr = 1'b0;
        check("ldclr_fields", 72'(fields), RST_FIELDS);
        check("ldclr_listo", 72'(listo), 72'h0);
        check("ldclr_hab", 72'(habilita), 72'h001);
        tick();
        check("ldclr_after", 72'(listo), 72'h0);

        // Selection wrap in both directions.
        press(DNP);
        check("sel_wrap_dn", 72'(habilita), 72'h100);
        press(UPP);
        check("sel_wrap_up", 72'(habilita), 72'h001);

        // Async reset drops listo mid-handshake.
        press(LD);
        check("ld3_listo", 72'(listo), 72'h1);
        rst_n = 1'b0;
        #1;
        check("async_listo", 72'(listo), 72'h0);
        check("async_hab", 72'(habilita), 72'h001);
        #2;
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
